// File: rtl/sdsu_bus_pkg.sv
// -----------------------------------------------------------------------------
// sdsu_bus_pkg
//
// Definitions shared by the SDSU bus Master, Slave and swap slave:
//   - default bus widths (BUS_DATA_W, BUS_ADDR_W)
//   - the responder state encoding (state_e: IDLE, WAIT, RESP)
//   - ERR_PATTERN, the word returned for out-of-range requests when
//     SDSU_BUS_ADDR_CHECK_EN is defined
//   - cnt_width(), the width of a down-counter that must hold a given value
// -----------------------------------------------------------------------------
package sdsu_bus_pkg;

   localparam int BUS_DATA_W = 32;
   localparam int BUS_ADDR_W = 32;

   localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Width of a counter that loads n and counts down to 1. Never below 1 so
   // that n = 0 still yields a legal vector.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sdsu_bus_swap_slave_if.sv
// -----------------------------------------------------------------------------
// sdsu_bus_swap_slave_if
//
// SDSU bus request/response bundle between a Master and a responder.
//   start, valid   : request strobe and its qualifier (Master -> responder)
//   address, data  : request word address and write data (Master -> responder)
//   ready          : one-cycle response strobe (responder -> Master)
//   result_data    : response word (responder -> Master)
//   busy           : responder is not idle (responder -> Master)
//   err            : out-of-range response flag, present only when
//                    SDSU_BUS_ADDR_CHECK_EN is defined
// -----------------------------------------------------------------------------
interface sdsu_bus_swap_slave_if
   import sdsu_bus_pkg::*;
#(
   parameter int DATA_W = BUS_DATA_W,
   parameter int ADDR_W = BUS_ADDR_W
);

   logic              start;
   logic              valid;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              ready;
   logic [DATA_W-1:0] result_data;
   logic              busy;
`ifdef SDSU_BUS_ADDR_CHECK_EN
   logic              err;
`endif

`ifdef SDSU_BUS_ADDR_CHECK_EN
   modport master (
      output start, valid, address, data,
      input  ready, result_data, busy, err
   );

   modport slave (
      input  start, valid, address, data,
      output ready, result_data, busy, err
   );
`else
   modport master (
      output start, valid, address, data,
      input  ready, result_data, busy
   );

   modport slave (
      input  start, valid, address, data,
      output ready, result_data, busy
   );
`endif

endinterface

// File: rtl/sdsu_bus_regfile.sv
// -----------------------------------------------------------------------------
// sdsu_bus_regfile
//
// DEPTH x DATA_W register array with one combinational read port and one
// synchronous write port. Every word is loaded with INIT_VALUE on reset.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   we       : write enable
//   wr_idx   : write word index
//   wr_data  : write data
//   rd_idx   : read word index
//   rd_data  : read data (combinational, reflects contents before this edge)
// -----------------------------------------------------------------------------
module sdsu_bus_regfile #(
   parameter int                DATA_W     = 32,
   parameter int                DEPTH      = 16,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0,
   localparam int               IW         = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IW-1:0]     wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IW-1:0]     rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array is built from flops rather than a RAM macro precisely so
   // that every word can be reset; a RAM-inferred array must not carry a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= INIT_VALUE;
         end
      end else if (we) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Read is combinational so the swap sees the pre-write word on the same
   // edge that stores the new one.
   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sdsu_bus_swap_slave.sv
// -----------------------------------------------------------------------------
// sdsu_bus_swap_slave
//
// Memory-backed SDSU bus responder. Each accepted request atomically swaps one
// word: the stored word at the addressed index is returned on result_data and
// the request data is written in its place. WAIT_CYCLES extra cycles are
// inserted between acceptance and response to model slow targets.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (drops any in-flight request)
//   bus  : sdsu_bus_swap_slave_if.slave
//            start, valid, address, data  in
//            ready, result_data, busy     out
//            err                          out (SDSU_BUS_ADDR_CHECK_EN only)
//
// Configuration macro:
//   SDSU_BUS_ADDR_CHECK_EN : when defined, an address >= DEPTH returns
//     ERR_PATTERN, writes nothing, and pulses err together with ready. When
//     undefined, the index wraps modulo DEPTH and there is no err output.
//
// Timing: a request accepted at edge N produces ready in the cycle after edge
// N+1+WAIT_CYCLES. busy covers the WAIT and RESP cycles; ready is registered
// at the edge that ends RESP, so at least one idle cycle separates requests.
// -----------------------------------------------------------------------------
module sdsu_bus_swap_slave
   import sdsu_bus_pkg::*;
#(
   parameter int                DATA_W      = BUS_DATA_W,
   parameter int                ADDR_W      = BUS_ADDR_W,
   parameter int                DEPTH       = 16,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   sdsu_bus_swap_slave_if.slave  bus
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = cnt_width(WAIT_CYCLES);

   localparam logic [CW-1:0]     WAIT_LOAD = CW'(WAIT_CYCLES);
   localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
   localparam logic [DATA_W-1:0] ERR_VALUE = DATA_W'(ERR_PATTERN);

   // Legacy-compatible state constants, tied to the shared enum encoding.
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_WAIT = WAIT;
   localparam logic [1:0] ST_RESP = RESP;

   // With no wait states, acceptance goes straight to the response cycle.
   localparam logic [1:0] ST_AFTER_ACCEPT = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;

   logic [1:0]        state;
   logic [CW-1:0]     wait_cnt;
   logic [IW-1:0]     idx_q;
   logic [DATA_W-1:0] data_q;
   logic              ready_q;
   logic [DATA_W-1:0] result_q;
   logic              oor_q;
   logic              accept;
   logic              wr_en;
   logic [DATA_W-1:0] rd_data;

   // Requests are only looked at in IDLE; anything arriving while busy is
   // dropped without latching.
   assign accept = (state == ST_IDLE) && bus.start && bus.valid;

   // --------------------------------------------------------------------------
   // Request FSM, wait counter and registered response
   // --------------------------------------------------------------------------
   // NOTE: every register here is written with <= so that all of them sample
   // the pre-edge values of state and the other flops, whatever the order of
   // the statements below.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         // ready is a single-cycle strobe; only RESP raises it.
         ready_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  idx_q    <= bus.address[IW-1:0];
                  data_q   <= bus.data;
                  wait_cnt <= WAIT_LOAD;
                  state    <= ST_AFTER_ACCEPT;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - CNT_ONE;
               if (wait_cnt == CNT_ONE) begin
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               ready_q  <= 1'b1;
               // rd_data is the word before this edge's write lands.
               result_q <= oor_q ? ERR_VALUE : rd_data;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Out-of-range tracking
   // --------------------------------------------------------------------------
`ifdef SDSU_BUS_ADDR_CHECK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         oor_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         err_q <= (state == ST_RESP) && oor_q;
         if (accept) begin
            oor_q <= (bus.address >= ADDR_W'(DEPTH));
         end
      end
   end

   assign bus.err = err_q;
`else
   // Without the range check every address wraps, so nothing is ever flagged.
   assign oor_q = 1'b0;
`endif

   // Address bits above the index only matter to the range check.
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.address[ADDR_W-1:IW];

   // --------------------------------------------------------------------------
   // Storage: write and read share the latched index and happen on the edge
   // that ends RESP, so back-to-back swaps to one word need no forwarding.
   // --------------------------------------------------------------------------
   assign wr_en = (state == ST_RESP) && !oor_q;

   sdsu_bus_regfile #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .INIT_VALUE (INIT_VALUE)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_en),
      .wr_idx  (idx_q),
      .wr_data (data_q),
      .rd_idx  (idx_q),
      .rd_data (rd_data)
   );

   assign bus.ready       = ready_q;
   assign bus.result_data = result_q;
   assign bus.busy        = (state != ST_IDLE);

endmodule
